// File: rtl/ethernet_pkg.sv
// Shared Ethernet constants and types for the GMII receive path.
package ethernet_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} gmii_rx_state_t;

endpackage

// File: rtl/gmii_rx_framer_if.sv
// GMII receive pins plus the framed sof/eof/valid/data byte stream.
// err_out exists only when GMII_RX_ERR_EN is defined.
interface gmii_rx_framer_if;

  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;

  logic       sof_out;
  logic       eof_out;
  logic       valid_out;
  logic [7:0] data_out;
  logic       drop_out;
`ifdef GMII_RX_ERR_EN
  logic       err_out;
`endif

  // The framer drives the byte stream; the consumer drives the GMII pins in a bench.
  modport master (
    input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
`ifdef GMII_RX_ERR_EN
    output err_out,
`endif
    output sof_out, eof_out, valid_out, data_out, drop_out
  );

  modport slave (
    output gmii_rx_dv, gmii_rx_er, gmii_rxd,
`ifdef GMII_RX_ERR_EN
    input  err_out,
`endif
    input  sof_out, eof_out, valid_out, data_out, drop_out
  );

endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, emits DA..FCS as sof/eof/valid/data.
// Define GMII_RX_ERR_EN to add err_out, flagging frames that carried rx_er in data.
module gmii_rx_framer
  import ethernet_pkg::*;
#(
  parameter int MAX_BYTES    = 1522,
  parameter int MAX_PREAMBLE = 7
) (
  input  logic              lcl_clk,
  input  logic              reset_n,
  gmii_rx_framer_if.master  bus
);

  localparam logic [10:0] BYTE_LIMIT = 11'(MAX_BYTES);
  localparam logic [2:0]  PRE_LIMIT  = 3'(MAX_PREAMBLE);

  logic           rx_dv_s1, rx_er_s1, rx_dv_q;
  logic [7:0]     rxd_s1;
  gmii_rx_state_t state, state_d;
  logic [2:0]     pre_cnt, pre_cnt_d, pre_base;
  logic [10:0]    byte_cnt, byte_cnt_d;
  logic [7:0]     hold, hold_d;
  logic           hold_vld, hold_vld_d;
  logic           sof_q, sof_d, eof_q, eof_d, valid_q, valid_d, drop_q, drop_d;
  logic [7:0]     data_q, data_d;
  logic           dv_rise;
`ifdef GMII_RX_ERR_EN
  logic           err_flag, err_flag_d, err_q, err_d;
`endif

  assign dv_rise = rx_dv_s1 && !rx_dv_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned and infers a latch.
    state_d    = state;
    pre_cnt_d  = pre_cnt;
    byte_cnt_d = byte_cnt;
    hold_d     = hold;
    hold_vld_d = hold_vld;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    valid_d    = 1'b0;
    drop_d     = 1'b0;
    data_d     = 8'h00;
`ifdef GMII_RX_ERR_EN
    err_flag_d = err_flag;
    err_d      = 1'b0;
`endif
    // The byte that raises rx_dv is already the first preamble byte, counted from zero.
    pre_base = (state == IDLE) ? 3'd0 : pre_cnt;

    case (state)
      IDLE, PRE: begin
        if (state == PRE || dv_rise) begin
          if (state == IDLE) begin
            byte_cnt_d = 11'd0;
            hold_vld_d = 1'b0;
`ifdef GMII_RX_ERR_EN
            err_flag_d = 1'b0;
`endif
          end
          if (!rx_dv_s1) begin
            state_d = IDLE;
          end else if (rx_er_s1) begin
            state_d = DROP;
            drop_d  = 1'b1;
          end else if (rxd_s1 == PREAMBLE_BYTE) begin
            if (pre_base == PRE_LIMIT) begin
              state_d = DROP;
              drop_d  = 1'b1;
            end else begin
              state_d   = PRE;
              pre_cnt_d = (pre_base == 3'd7) ? pre_base : pre_base + 3'd1;
            end
          end else if (rxd_s1 == SFD_BYTE && pre_base != 3'd0) begin
            state_d = DATA;
          end else begin
            state_d = DROP;
            drop_d  = 1'b1;
          end
        end
      end

      DATA: begin
        if (!rx_dv_s1) begin
          // End of frame: flush the held byte as the last one (nothing if the frame was empty).
          valid_d    = hold_vld;
          eof_d      = hold_vld;
          data_d     = hold_vld ? hold : 8'h00;
`ifdef GMII_RX_ERR_EN
          err_d      = hold_vld && err_flag;
`endif
          hold_vld_d = 1'b0;
          state_d    = IDLE;
        end else if (byte_cnt >= BYTE_LIMIT) begin
          // A byte beyond the limit arrived: close the frame on the held byte and discard the tail.
          valid_d    = 1'b1;
          eof_d      = 1'b1;
          drop_d     = 1'b1;
          data_d     = hold;
`ifdef GMII_RX_ERR_EN
          err_d      = err_flag;
`endif
          hold_vld_d = 1'b0;
          state_d    = DROP;
        end else begin
          valid_d    = hold_vld;
          data_d     = hold_vld ? hold : 8'h00;
          sof_d      = !hold_vld;
          hold_d     = rxd_s1;
          hold_vld_d = 1'b1;
          byte_cnt_d = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
`ifdef GMII_RX_ERR_EN
          err_flag_d = err_flag || rx_er_s1;
`endif
        end
      end

      DROP: if (!rx_dv_s1) state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge lcl_clk or negedge reset_n) begin
    if (!reset_n) begin
      // rx_dv is held "high" through reset so a frame already in flight never looks like a rising edge.
      rx_dv_s1 <= 1'b1;
      rx_dv_q  <= 1'b1;
      rx_er_s1 <= 1'b0;
      rxd_s1   <= 8'h00;
      state    <= IDLE;
      pre_cnt  <= 3'd0;
      byte_cnt <= 11'd0;
      // NOTE: hold data is gated by hold_vld, but it is reset too so data_out never carries X.
      hold     <= 8'h00;
      hold_vld <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      data_q   <= 8'h00;
`ifdef GMII_RX_ERR_EN
      err_flag <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      rx_dv_s1 <= bus.gmii_rx_dv;
      rx_dv_q  <= rx_dv_s1;
      rx_er_s1 <= bus.gmii_rx_er;
      rxd_s1   <= bus.gmii_rxd;
      state    <= state_d;
      pre_cnt  <= pre_cnt_d;
      byte_cnt <= byte_cnt_d;
      hold     <= hold_d;
      hold_vld <= hold_vld_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
      data_q   <= data_d;
`ifdef GMII_RX_ERR_EN
      err_flag <= err_flag_d;
      err_q    <= err_d;
`endif
    end
  end

  assign bus.sof_out   = sof_q;
  assign bus.eof_out   = eof_q;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.drop_out  = drop_q;
`ifdef GMII_RX_ERR_EN
  assign bus.err_out   = err_q;
`endif

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: drives GMII pins, records the framed stream, compares to hand values.
module tb_gmii_rx_framer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  gmii_rx_framer_if bus ();

  gmii_rx_framer #(.MAX_BYTES(1522), .MAX_PREAMBLE(7)) dut (
    .lcl_clk (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [7:0] got_data[$];
  bit         got_eof[$];
`ifdef GMII_RX_ERR_EN
  bit         got_err[$];
`endif
  int sof_cnt, drop_cnt, eof_cnt, first_valid_cyc;
  bit prev_sof, in_frame;

  task automatic clear_mon();
    got_data.delete();
    got_eof.delete();
`ifdef GMII_RX_ERR_EN
    got_err.delete();
`endif
    sof_cnt = 0; drop_cnt = 0; eof_cnt = 0; first_valid_cyc = -1;
    prev_sof = 1'b0; in_frame = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.sof_out)  sof_cnt++;
    if (bus.drop_out) drop_cnt++;
    if (bus.valid_out) begin
      if (!in_frame) begin
        check("sof_lead", {31'b0, prev_sof}, 32'd1);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      got_data.push_back(bus.data_out);
      got_eof.push_back(bus.eof_out);
`ifdef GMII_RX_ERR_EN
      got_err.push_back(bus.err_out);
`endif
      if (bus.eof_out) eof_cnt++;
      in_frame = !bus.eof_out;
    end
    prev_sof = bus.sof_out;
  end

  // Stimulus
  logic [7:0] tx_q[$];
  int er_idx   = -1;
  int data_pos = 0;
  int drive_cyc = 0;

  task automatic drive(input bit dv, input bit er, input logic [7:0] d);
    @(negedge clk);
    bus.gmii_rx_dv = dv;
    bus.gmii_rx_er = er;
    bus.gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic build(input int npre, input int n, input logic [7:0] start);
    tx_q.delete();
    repeat (npre) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) tx_q.push_back(8'(int'(start) + i));
    data_pos = npre + 1;
  endtask

  task automatic send_raw();
    foreach (tx_q[i]) begin
      drive(1'b1, (i == er_idx), tx_q[i]);
      if (i == data_pos) drive_cyc = cyc;
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  int bad;

  initial begin
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = 8'h00;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_outs", {19'b0, bus.sof_out, bus.eof_out, bus.valid_out, bus.drop_out, bus.data_out}, 32'd0);
    rst_n = 1'b1;
    idle(4);

    // 1: standard 64-byte frame 00..3F
    clear_mon();
    build(7, 64, 8'h00);
    send_raw();
    idle(8);
    check("t1_sof", sof_cnt, 1);
    check("t1_len", got_data.size(), 64);
    bad = 0;
    foreach (got_data[i]) if (got_data[i] !== 8'(i)) bad++;
    check("t1_data", bad, 0);
    check("t1_eof_cnt", eof_cnt, 1);
    check("t1_eof_pos", {31'b0, got_eof[63]}, 1);
    check("t1_drop", drop_cnt, 0);
    check("t1_latency", first_valid_cyc - drive_cyc, 3);
`ifdef GMII_RX_ERR_EN
    check("t1_err", {31'b0, got_err[63]}, 0);
`endif

    // 2: bad preamble then a good frame
    clear_mon();
    tx_q.delete();
    tx_q = '{8'h55, 8'h55, 8'hAA, 8'hD5, 8'h10, 8'h11, 8'h12};
    send_raw();
    idle(2);
    build(7, 8, 8'h30);
    send_raw();
    idle(8);
    check("t2_drop", drop_cnt, 1);
    check("t2_sof", sof_cnt, 1);
    check("t2_len", got_data.size(), 8);
    bad = 0;
    foreach (got_data[i]) if (got_data[i] !== 8'(8'h30 + i)) bad++;
    check("t2_data", bad, 0);

    // 3: oversize frame truncated at 1522 bytes
    clear_mon();
    build(7, 2000, 8'h00);
    send_raw();
    idle(8);
    check("t3_len", got_data.size(), 1522);
    bad = 0;
    foreach (got_data[i]) if (got_data[i] !== 8'(i)) bad++;
    check("t3_data", bad, 0);
    check("t3_eof_cnt", eof_cnt, 1);
    check("t3_eof_pos", {31'b0, got_eof[1521]}, 1);
    check("t3_drop", drop_cnt, 1);
    check("t3_sof", sof_cnt, 1);

    // 4: back-to-back frames with a 1-cycle rx_dv gap
    clear_mon();
    build(7, 64, 8'h00);
    send_raw();
    build(7, 64, 8'h40);
    send_raw();
    idle(8);
    check("t4_sof", sof_cnt, 2);
    check("t4_len", got_data.size(), 128);
    bad = 0;
    foreach (got_data[i]) if (got_data[i] !== 8'(i)) bad++;
    check("t4_data", bad, 0);
    check("t4_eof_cnt", eof_cnt, 2);
    check("t4_eof_pos", {30'b0, got_eof[63], got_eof[127]}, 3);

    // 5: reset mid-DATA, released while rx_dv stays high
    build(7, 40, 8'h80);
    for (int i = 0; i < 18; i++) drive(1'b1, 1'b0, tx_q[i]);
    #1 rst_n = 1'b0;
    #1 check("t5_rst_outs", {19'b0, bus.sof_out, bus.eof_out, bus.valid_out, bus.drop_out, bus.data_out}, 32'd0);
    clear_mon();
    for (int i = 18; i < 20; i++) drive(1'b1, 1'b0, tx_q[i]);
    rst_n = 1'b1;
    for (int i = 20; i < 48; i++) drive(1'b1, 1'b0, tx_q[i]);
    idle(8);
    check("t5_quiet_valid", got_data.size(), 0);
    check("t5_quiet_sof", sof_cnt, 0);
    check("t5_quiet_drop", drop_cnt, 0);
    clear_mon();
    build(7, 16, 8'h20);
    send_raw();
    idle(8);
    check("t5_len", got_data.size(), 16);
    bad = 0;
    foreach (got_data[i]) if (got_data[i] !== 8'(8'h20 + i)) bad++;
    check("t5_data", bad, 0);

    // 6: one-byte frame, rx_er asserted on that byte
    clear_mon();
    build(7, 1, 8'hA5);
    er_idx = 8;
    send_raw();
    er_idx = -1;
    idle(8);
    check("t6_sof", sof_cnt, 1);
    check("t6_len", got_data.size(), 1);
    check("t6_data", {24'b0, got_data[0]}, 32'hA5);
    check("t6_eof", {31'b0, got_eof[0]}, 1);
    check("t6_drop", drop_cnt, 0);
`ifdef GMII_RX_ERR_EN
    check("t6_err", {31'b0, got_err[0]}, 1);
`endif

    // 7: preamble boundaries, rx_er in preamble, empty frame
    clear_mon();
    build(8, 4, 8'h00);
    send_raw();
    idle(6);
    check("t7_pre8_drop", drop_cnt, 1);
    check("t7_pre8_len", got_data.size(), 0);

    clear_mon();
    build(1, 4, 8'h10);
    send_raw();
    idle(6);
    check("t7_pre1_len", got_data.size(), 4);
    check("t7_pre1_last", {24'b0, got_data[3]}, 32'h13);
    check("t7_pre1_drop", drop_cnt, 0);

    clear_mon();
    build(7, 4, 8'h00);
    er_idx = 3;
    send_raw();
    er_idx = -1;
    idle(6);
    check("t7_er_pre_drop", drop_cnt, 1);
    check("t7_er_pre_sof", sof_cnt, 0);

    clear_mon();
    build(7, 0, 8'h00);
    send_raw();
    idle(6);
    check("t7_empty_sof", sof_cnt, 0);
    check("t7_empty_len", got_data.size(), 0);
    check("t7_empty_drop", drop_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
